mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit owning the HI/LO registers of the single-cycle MIPS core. It sits directly downstream of the datapath's register-read stage and the controller's `multLoad` strobe. It consumes rs/rt operands and returns HI/LO to the write-back mux for `mfhi`/`mflo`. While an operation runs it raises `busy`, and the controller uses `busy` to freeze the PC.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`, input, 1: the only clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: driven from `multLoad`; begins an operation when the unit is idle.
- `op`, input, 2: operation select. 00 = mult, 01 = multu, 10 = div, 11 = divu.
- `a`, input, WIDTH: rs operand (multiplicand or dividend).
- `b`, input, WIDTH: rt operand (multiplier or divisor).
- `hiWrite`, input, 1: `mthi` strobe.
- `loWrite`, input, 1: `mtlo` strobe.
- `wdata`, input, WIDTH: data for `mthi`/`mtlo`.
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle pulse after HI/LO are updated.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE, `start`=1: latch `op`, `a`, `b`; go to PREP.
- PREP (1 cycle): form operand magnitudes for signed ops; record the result signs; clear the accumulator; counter = 0.
- RUN (32 cycles):
  - Multiply: radix-2 shift-add into a 64-bit product.
  - Divide: restoring algorithm, one quotient bit per cycle.
  - Counter increments each cycle; leave RUN when counter = 31.
- FIX (1 cycle):
  - Apply sign correction. Product sign = sign(a) XOR sign(b). Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Write HI/LO and return to IDLE.
- Result mapping:
  - mult/multu: {HI, LO} = 64-bit product.
  - div/divu: LO = quotient, HI = remainder.
- Divide by zero (b = 0, signed or unsigned): LO = all ones, HI = a. Latency is the same as a normal divide.
- Signed overflow case (div 0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- `mthi`/`mtlo`: honoured only in IDLE with `start`=0. HI or LO takes `wdata` at the next edge. Both strobes together write both registers.
- Ignored inputs:
  - `start` while busy is ignored.
  - `hiWrite`/`loWrite` while busy, or in the same cycle as an accepted `start`, are ignored.
- Operand changes after the `start` cycle have no effect.

## Timing
- Reset values: state = IDLE; `busy` = 0; `done` = 0; `hi` = 0; `lo` = 0; counter = 0.
- `start` sampled at edge E0 → `busy` = 1 from E0 through E0+34 (PREP + 32 RUN + FIX = 34 cycles).
- HI/LO update at edge E0+34.
- `busy` falls and `done` rises at edge E0+34. `done` falls at E0+35.
- A new `start` is accepted at E0+34 at the earliest, i.e. back-to-back with zero idle cycles when `start` is held at the `busy`-falling edge.
- `hi`/`lo` are registered outputs. During an operation they hold their previous values; no partial results are visible.
- `rst` asserted in any state: return to reset values at that edge. The operation in flight is abandoned and `done` does not pulse.
- `busy` is a registered output and never has a combinational path from `start`. The controller's stall logic covers the `start` cycle itself.

## Structure
- Shared package `mips_pkg` holds:
  - the `op` encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`);
  - the MDU state enum;
  - the cycle-count constant `MDU_CYCLES` = 32.
- Sub-module `mdu_step`: purely combinational single-iteration step. One add/shift for multiply; one trial-subtract for divide. Instantiated once inside `mult_div_unit`. All sequencing stays in the top module.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `busy` high exactly 34 cycles. `done` pulses once.
- mult a=0xFFFFFFFD (−3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=100, b=7 → LO=14, HI=2.
- divu a=0x64, b=0 → LO=0xFFFFFFFF, HI=0x64. div a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- `start` pulsed again at RUN cycle 5, and `hiWrite` with `wdata`=0x12345678 during RUN → both ignored, first result intact. After idle, `hiWrite` with 0x12345678 → HI=0x12345678, LO unchanged.
- `rst` at RUN cycle 10 → next cycle `busy`=0, HI=LO=0, no `done`. A subsequent `start` completes normally in 34 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core's multiply/divide unit.
package mips_pkg;

  // Operation encodings carried on the MDU op input
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // MDU sequencer states
  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_PREP = 2'd1;
  localparam logic [1:0] MDU_RUN  = 2'd2;
  localparam logic [1:0] MDU_FIX  = 2'd3;

  // One iteration per operand bit
  localparam int unsigned MDU_CYCLES = 32;

  function automatic logic mdu_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic mdu_is_div(input logic [1:0] op);
    return !((op == MDU_MULT) || (op == MDU_MULTU));
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU: a shift-add for multiply or a restoring
// trial-subtract for divide. Purely combinational; sequencing is in the top.
module mdu_step
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_part;
  logic [WIDTH:0] w_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  always_comb begin
    w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_part = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff = w_part - {1'b0, i_opnd};
    if (i_div) begin
      // Borrow out of the trial subtract means the divisor did not fit
      if (!w_diff[WIDTH]) begin
        o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_part[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers. Operations take
// 34 cycles (prep, 32 iterations, sign fix) and raise busy throughout.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hi_write,
  input  logic             i_lo_write,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned     CNT_W    = $clog2(MDU_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_CYCLES - 1);

  logic [1:0]         r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_signed;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_div  (w_is_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step)
  );

  // Operand magnitudes for PREP and sign-corrected results for FIX
  always_comb begin
    w_signed = mdu_is_signed(r_op);
    w_is_div = mdu_is_div(r_op);
    w_a_neg  = w_signed & r_a[WIDTH-1];
    w_b_neg  = w_signed & r_b[WIDTH-1];
    w_a_mag  = w_a_neg ? -r_a : r_a;
    w_b_mag  = w_b_neg ? -r_b : r_b;
    w_prod   = r_neg_q ? -r_acc : r_acc;
    // Divide by zero yields quotient all ones; the remainder path already
    // reproduces a, so only LO needs overriding
    w_quo    = r_div0 ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer, datapath registers and HI/LO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= MDU_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MDU_IDLE: begin
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_a;
            r_b     <= i_b;
            r_busy  <= 1'b1;
            r_state <= MDU_PREP;
          end else begin
            if (i_hi_write) r_hi <= i_wdata;
            if (i_lo_write) r_lo <= i_wdata;
          end
        end
        MDU_PREP: begin
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_div0  <= w_is_div && (r_b == '0);
          r_cnt   <= '0;
          r_acc   <= w_is_div ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
          r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
          r_state <= MDU_RUN;
        end
        MDU_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= MDU_FIX;
        end
        default: begin
          if (w_is_div) begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end else begin
            r_lo <= w_prod[WIDTH-1:0];
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
          end
          r_done <= 1'b1;
          // A start held on the finishing edge chains straight into PREP
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_a;
            r_b     <= i_b;
            r_state <= MDU_PREP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= MDU_IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_hi_write;
  logic        i_lo_write;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 i_clk = ~i_clk;

  mult_div_unit #(
    .WIDTH (32)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_hi_write (i_hi_write),
    .i_lo_write (i_lo_write),
    .i_wdata    (i_wdata),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {HI, LO} from MIPS arithmetic rules
  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sp;
    int     sa;
    int     sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    i_start    = 1'b1;
    i_op       = op;
    i_a        = a;
    i_b        = b;
    // Strobes alongside an accepted start must be ignored
    i_hi_write = 1'b1;
    i_lo_write = 1'b1;
    i_wdata    = $urandom;
  endtask

  // Observe one operation; k counts negedges after the start edge
  task automatic watch(input logic [63:0] exp, input logic [31:0] hi0, input logic [31:0] lo0,
                       input bit inject, input bit chain, input int k0,
                       input logic [1:0] c_op, input logic [31:0] c_a, input logic [31:0] c_b);
    int k;
    int busy_cyc;
    int done_k;
    bit seen;
    k        = k0;
    busy_cyc = k0 - 1;
    done_k   = -1;
    seen     = 1'b0;
    while (!seen && k < 120) begin
      @(negedge i_clk);
      if (k == 1) begin
        i_start    = 1'b0;
        i_hi_write = 1'b0;
        i_lo_write = 1'b0;
        i_a        = $urandom;
        i_b        = $urandom;
        i_op       = 2'($urandom);
      end
      if (inject && k == 7) begin
        i_start    = 1'b1;
        i_hi_write = 1'b1;
        i_wdata    = 32'h1234_5678;
      end
      if (inject && k == 8) begin
        i_start    = 1'b0;
        i_hi_write = 1'b0;
      end
      if (chain && k == 34) begin
        i_start = 1'b1;
        i_op    = c_op;
        i_a     = c_a;
        i_b     = c_b;
      end
      if (k == 17) begin
        check_val("hold_hi", o_hi, hi0);
        check_val("hold_lo", o_lo, lo0);
      end
      if (o_done) begin
        seen   = 1'b1;
        done_k = k;
      end else if (o_busy) begin
        busy_cyc++;
      end
      k++;
    end
    check_val("done_seen", seen, 1);
    check_val("done_cycle", done_k, 35);
    check_val("busy_cycles", busy_cyc, 34);
    check_val("busy_at_done", o_busy, chain);
    check_val("hi", o_hi, exp[63:32]);
    check_val("lo", o_lo, exp[31:0]);
    if (chain) begin
      i_start = 1'b0;
      i_a     = $urandom;
      i_b     = $urandom;
    end else begin
      @(negedge i_clk);
      check_val("done_fall", {o_done, o_busy}, 2'b00);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [63:0] exp;
    exp = ref_mdu(op, a, b);
    issue(op, a, b);
    watch(exp, m_hi, m_lo, inject, 1'b0, 1, 2'b00, 32'd0, 32'd0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic move_to(input bit hw, input bit lw, input logic [31:0] data);
    @(negedge i_clk);
    i_hi_write = hw;
    i_lo_write = lw;
    i_wdata    = data;
    @(negedge i_clk);
    i_hi_write = 1'b0;
    i_lo_write = 1'b0;
    if (hw) m_hi = data;
    if (lw) m_lo = data;
    check_val("mt_hi", o_hi, m_hi);
    check_val("mt_lo", o_lo, m_lo);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e1;
    logic [63:0] e2;
    int          sel;

    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_op       = 2'b00;
    i_a        = '0;
    i_b        = '0;
    i_hi_write = 1'b0;
    i_lo_write = 1'b0;
    i_wdata    = '0;
    m_hi       = '0;
    m_lo       = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    check_val("reset_state", {o_busy, o_done, o_hi, o_lo}, 66'd0);

    // Directed cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b11, 32'h64, 32'd0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

    // Start and mthi during RUN are ignored
    run_op(2'b00, 32'h0001_2345, 32'hFFFF_0003, 1'b1);
    move_to(1'b1, 1'b0, 32'h1234_5678);
    move_to(1'b0, 1'b1, 32'hCAFE_F00D);
    move_to(1'b1, 1'b1, 32'h0BAD_BEEF);

    // Back-to-back: start held at the finishing edge
    e1 = ref_mdu(2'b01, 32'hDEAD_BEEF, 32'h0000_1001);
    e2 = ref_mdu(2'b10, 32'h8765_4321, 32'h0000_0013);
    issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1001);
    watch(e1, m_hi, m_lo, 1'b0, 1'b1, 1, 2'b10, 32'h8765_4321, 32'h0000_0013);
    m_hi = e1[63:32];
    m_lo = e1[31:0];
    watch(e2, m_hi, m_lo, 1'b0, 1'b0, 2, 2'b00, 32'd0, 32'd0);
    m_hi = e2[63:32];
    m_lo = e2[31:0];

    // Reset in the middle of RUN abandons the operation
    issue(2'b11, 32'h0F0F_0F0F, 32'd3);
    @(negedge i_clk);
    i_start    = 1'b0;
    i_hi_write = 1'b0;
    i_lo_write = 1'b0;
    repeat (10) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    check_val("rst_mid", {o_busy, o_done, o_hi, o_lo}, 66'd0);
    sel = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_done || o_busy) sel++;
    end
    check_val("rst_no_done", sel, 0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);

    // Randomized operations with a bias toward corner operands
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom);
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (sel == 2) b = $urandom_range(1, 15);
      if (sel == 3) a = $urandom_range(0, 255);
      run_op(op, a, b, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
